// File: rtl/tlp_fifo_arb_if.sv
// Handshake bundle between tlp_fifo_arb, its two FWFT TLP FIFOs and the
// downstream Ethernet-encapsulation consumer.
//
// Entry layout (PCIE_FIFO64_RX, 75 bits):
//   [74]    data_valid  (0 = bubble entry)
//   [73]    tlp.tvalid
//   [72]    tlp.tlast
//   [71:64] tlp.tkeep
//   [63:0]  tlp.tdata   (header beats carry field.len / tag here)
interface tlp_fifo_arb_if;
  logic [1:0][74:0] src_dout;
  logic [1:0]       src_empty;
  logic [1:0]       src_rd_en;
  logic             out_tvalid;
  logic             out_tready;
  logic [74:0]      out_entry;
  logic             out_sop;
  logic             out_src;
  logic             out_err;

  // Arbiter side
  modport master (
    input  src_dout, src_empty, out_tready,
    output src_rd_en, out_tvalid, out_entry, out_sop, out_src, out_err
  );

  // FIFO / consumer side
  modport slave (
    output src_dout, src_empty, out_tready,
    input  src_rd_en, out_tvalid, out_entry, out_sop, out_src, out_err
  );
endinterface

// File: rtl/tlp_fifo_arb.sv
// Packet-level round-robin arbiter between two TLP FIFOs and one consumer.
// Bubbles are dropped, TLPs are never interleaved, and a TLP whose source
// stalls mid-packet is closed with a synthetic error terminator beat.
module tlp_fifo_arb #(
  parameter int unsigned STALL_MAX = 1024
) (
  input  logic           pcie_clk,
  input  logic           pcie_rst_n,
  tlp_fifo_arb_if.master bus,
  output logic [15:0]    pkt_cnt0,
  output logic [15:0]    pkt_cnt1,
  output logic [15:0]    abort_cnt
);

  localparam int unsigned EntryW = 75;
  localparam int unsigned DvBit  = 74;
  localparam int unsigned LastBit = 72;
  // Terminator: data_valid=1, tvalid=1, tlast=1, tkeep=0, data=0.
  localparam logic [EntryW-1:0] AbortBeat = {3'b111, 72'd0};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StAbort = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        rr_q, rr_d;
  logic        sop_q, sop_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] pkt0_q, pkt0_d;
  logic [15:0] pkt1_q, pkt1_d;
  logic [15:0] abort_q, abort_d;

  logic [1:0]        elig, bubble;
  logic [EntryW-1:0] head;
  logic [16:0]       stall_inc;
  logic [1:0]        rd_en_c;
  logic              tvalid_c, err_c;
  logic [EntryW-1:0] entry_c;

  // Per-source head classification
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i]   = !bus.src_empty[i] && bus.src_dout[i][DvBit];
      bubble[i] = !bus.src_empty[i] && !bus.src_dout[i][DvBit];
    end
  end

  assign head      = bus.src_dout[sel_q];
  assign stall_inc = {1'b0, stall_q} + 17'd1;

  // Next-state, counters and combinational outputs
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    sop_d    = sop_q;
    stall_d  = stall_q;
    pkt0_d   = pkt0_q;
    pkt1_d   = pkt1_q;
    abort_d  = abort_q;
    rd_en_c  = 2'b00;
    tvalid_c = 1'b0;
    err_c    = 1'b0;
    entry_c  = '0;

    unique case (state_q)
      StIdle: begin
        // Bubbles on both heads may be dropped in the same cycle.
        rd_en_c = bubble;
        if (|elig) begin
          sel_d   = elig[rr_q] ? rr_q : ~rr_q;
          state_d = StXfer;
          stall_d = '0;
          sop_d   = 1'b1;
        end
      end

      StXfer: begin
        entry_c  = head;
        tvalid_c = elig[sel_q];
        if (tvalid_c && bus.out_tready) begin
          rd_en_c[sel_q] = 1'b1;
          stall_d        = '0;
          sop_d          = 1'b0;
          if (head[LastBit]) begin
            if (sel_q) pkt1_d = pkt1_q + 16'd1;
            else       pkt0_d = pkt0_q + 16'd1;
            rr_d    = ~sel_q;
            state_d = StIdle;
          end
        end else if (bubble[sel_q]) begin
          rd_en_c[sel_q] = 1'b1;
          stall_d        = '0;
        end else if (bus.src_empty[sel_q]) begin
          // Abort once STALL_MAX consecutive empty cycles have elapsed.
          stall_d = stall_inc[15:0];
          if (32'(stall_inc) == STALL_MAX) state_d = StAbort;
        end
      end

      StAbort: begin
        entry_c  = AbortBeat;
        tvalid_c = 1'b1;
        err_c    = 1'b1;
        if (bus.out_tready) begin
          if (abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
          rr_d    = ~sel_q;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      sop_q   <= 1'b0;
      stall_q <= '0;
      pkt0_q  <= '0;
      pkt1_q  <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      sop_q   <= sop_d;
      stall_q <= stall_d;
      pkt0_q  <= pkt0_d;
      pkt1_q  <= pkt1_d;
      abort_q <= abort_d;
    end
  end

  // IDLE bubble pops would otherwise leak through while reset is held.
  assign bus.src_rd_en  = rd_en_c & {2{pcie_rst_n}};
  assign bus.out_tvalid = tvalid_c;
  assign bus.out_entry  = entry_c;
  assign bus.out_err    = err_c;
  assign bus.out_src    = sel_q;
  assign bus.out_sop    = (state_q == StXfer) && sop_q && tvalid_c;

  assign pkt_cnt0  = pkt0_q;
  assign pkt_cnt1  = pkt1_q;
  assign abort_cnt = abort_q;

endmodule

// File: doc/tlp_fifo_arb.md
# tlp_fifo_arb

Packet-level round-robin arbiter between two TLP FIFOs of PCIE_FIFO64_RX entries (the format written by the PCIe RX capture stage) and the single downstream Ethernet-encapsulation consumer. It pops beats only when the consumer accepts them and discards bubble entries (data_valid=0). It never interleaves two TLPs, and it aborts a TLP cleanly if its source stalls mid-packet. It also keeps per-source packet and abort counters.

## Interface
- STALL_MAX, 1024: consecutive empty cycles on the granted FIFO mid-packet before abort; legal range 2..65535.
- pcie_clk  in  1  clock; all logic on rising edge.
- pcie_rst_n  in  1  asynchronous, active-low reset.
- src_dout[0:1]  in  2×PCIE_FIFO64_RX  head entries of FWFT FIFOs; valid when the matching src_empty is 0.
- src_empty[0:1]  in  2  FIFO empty flags.
- src_rd_en[0:1]  out  2  pop strobes; one entry popped per asserted cycle.
- out_tvalid  out  1  output beat valid.
- out_tready  in  1  consumer accepts beat.
- out_entry  out  PCIE_FIFO64_RX  beat; the src_dout of the granted source, or the synthetic abort beat.
- out_sop  out  1  first beat of a TLP (the header beat, whose field.len/tag are valid).
- out_src  out  1  granted source index.
- out_err  out  1  beat is a synthetic abort terminator.
- pkt_cnt0, pkt_cnt1  out  16 each  TLPs completed per source (tlast handshaked, not aborted); wrap modulo 2^16.
- abort_cnt  out  16  aborted TLPs, both sources; saturates at 0xFFFF.

## Operation
- Eligible source: !src_empty[i] && src_dout[i].data_valid.
- FSM states:
  - IDLE:
    - Any source whose head has data_valid=0 is popped, and both may pop in the same cycle.
    - If any source is eligible, latch grant sel, go to XFER. The rr pointer names the preferred source; with a single eligible source, that source wins.
  - XFER:
    - out_entry = src_dout[sel] and out_tvalid = !src_empty[sel] && src_dout[sel].data_valid.
    - src_rd_en[sel] = out_tvalid && out_tready.
    - A head with data_valid=0 in XFER is popped and dropped; out_tvalid stays 0 that cycle.
    - On a handshake with tlast=1: increment pkt_cnt[sel], set rr = ~sel, go to IDLE.
  - ABORT:
    - out_tvalid=1, out_err=1, out_entry all-zero except data_valid=1, tlp.tvalid=1, tlp.tlast=1, tkeep=0.
    - On handshake: abort_cnt++ (saturating), rr = ~sel, go to IDLE.
    - No pops in ABORT.
- out_sop is 1 on the first out_tvalid of each XFER, held until that beat handshakes.
- Stall counter (16-bit):
  - Cleared on entry to XFER and on every pop.
  - Increments each XFER cycle with src_empty[sel]=1.
  - Reaching STALL_MAX moves the FSM to ABORT on the next edge.
  - Consumer backpressure (out_tready=0) never counts as stall.
- The non-granted source is never popped in XFER or ABORT, not even its bubbles.
- Illegal state encodings go to IDLE.

## Timing
- Reset (pcie_rst_n=0, asynchronous) gives:
  - state=IDLE, rr=0, sel=0, all counters 0.
  - src_rd_en=0, out_tvalid=0, out_sop=0, out_err=0, out_src=0 — all forced while reset is held.
- A reset mid-packet truncates the TLP with no terminator. The FIFOs are reset by the same signal, so no residue remains.
- Arbitration latency: an eligible head first seen in IDLE at cycle N gives out_tvalid=1 at cycle N+1.
- At the tlast handshake at cycle M the FSM is in IDLE at M+1. The earliest next grant is out_tvalid at M+2, giving one idle cycle between TLPs.
- out_tvalid, out_entry, out_sop and src_rd_en are combinational from state/sel and the FIFO head; there is no output register. out_entry holds stable while out_tvalid=1 and out_tready=0.
- Throughput: one beat per cycle inside a TLP when the FIFO is non-empty and out_tready=1.

## Test plan
- Single source: src0 holds a 4-beat MWr (header, header, data, data+tlast) followed by a bubble, out_tready=1 → 4 consecutive out_tvalid beats with out_sop on the first, out_src=0; the bubble is popped in IDLE and not forwarded; pkt_cnt0=1.
- Both sources hold 3 TLPs each from reset → grant order 0,1,0,1,0,1 with no interleaving; pkt_cnt0=pkt_cnt1=3.
- Backpressure: toggle out_tready every cycle during a 4-beat TLP → each beat held stable until accepted; src_rd_en only on accepted cycles; stall counter stays 0.
- Stall abort with STALL_MAX=8: src0 supplies the header then goes empty → ABORT beat (out_err=1, tlast=1, tkeep=0) appears 8 cycles after the last pop; abort_cnt=1; pkt_cnt0 unchanged; src1 is granted next.
- Mid-packet reset: assert pcie_rst_n=0 during beat 2 → outputs and counters return to reset values in the same cycle; after release, a fresh TLP from src1 completes normally.
- Counter wrap/saturate: preload pkt_cnt1 near its limit via 65537 single-beat TLPs → reads 1; force 65536 aborts → abort_cnt holds 0xFFFF.
